entity_motion_ctrl: RTL and testbench

ENTITY_MOTION_CTRL -- requirements
Module: entity_motion_ctrl

---
 rtl/hk_pkg.sv | 39 +++
 rtl/aabb_overlap.sv | 34 +++
 rtl/entity_motion_ctrl.sv | 172 +++++++++++++++++
 tb/tb_entity_motion_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hk_pkg.sv
// Shared definitions for the entity motion controller: update-sequence
// states, screen geometry, HID keycodes and a saturating position step.
// Ports: none (package).
package hk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_P  = 2'd1,
    MOVE_E  = 2'd2,
    HIT_CHK = 2'd3
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [7:0] KEY_A = 8'h04;  // left
  localparam logic [7:0] KEY_D = 8'h07;  // right
  localparam logic [7:0] KEY_W = 8'h1A;  // up
  localparam logic [7:0] KEY_S = 8'h16;  // down

  // Adds a signed delta to a 10-bit coordinate in 12-bit signed space so an
  // overshoot past either edge saturates at the bound instead of wrapping.
  function automatic logic [9:0] clamp_step(
    input logic [9:0]        pos,
    input logic signed [11:0] delta,
    input logic [9:0]        lo,
    input logic [9:0]        hi
  );
    logic signed [11:0] sum;
    sum = $signed({2'b00, pos}) + delta;
    if (sum < $signed({2'b00, lo}))
      return lo;
    else if (sum > $signed({2'b00, hi}))
      return hi;
    else
      return sum[9:0];
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned box overlap test on centre coordinates (combinational).
// Ports: ax/ay/aw/ah box A centre and size, bx/by/bw/bh box B centre and
// size, overlap high when 2*|dx| < aw+bw and 2*|dy| < ah+bh.
module aabb_overlap (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] aw,
  input  logic [9:0] ah,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] bw,
  input  logic [9:0] bh,
  output logic       overlap
);

  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [10:0] dx2;
  logic [10:0] dy2;
  logic [10:0] sum_w;
  logic [10:0] sum_h;

  // Doubling the distance instead of halving the sizes keeps odd sizes exact.
  always_comb begin
    dx    = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy    = (ay >= by) ? (ay - by) : (by - ay);
    dx2   = {dx, 1'b0};
    dy2   = {dy, 1'b0};
    sum_w = {1'b0, aw} + {1'b0, bw};
    sum_h = {1'b0, ah} + {1'b0, bh};
    overlap = (dx2 < sum_w) && (dy2 < sum_h);
  end

endmodule

// File: rtl/entity_motion_ctrl.sv
// Per-frame player/enemy motion, enemy wall bounce, and hit/health tracking.
// Ports: Clk/Reset (async active-high), frame_clk tick, keycode (HID);
// outputs player/enemy centres and sizes, hp, invuln, dead (all registered).
module entity_motion_ctrl
  import hk_pkg::*;
#(
  parameter int PLAYER_W     = 32,
  parameter int PLAYER_H     = 48,
  parameter int ENEMY_W      = 40,
  parameter int ENEMY_H      = 40,
  parameter int STEP         = 2,
  parameter int HIT_COOLDOWN = 60,
  parameter int MAX_HP       = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_sizeX,
  output logic [9:0] Ball_sizeY,
  output logic [9:0] BallX1,
  output logic [9:0] BallY1,
  output logic [9:0] Ball_sizeX1,
  output logic [9:0] Ball_sizeY1,
  output logic [2:0] hp,
  output logic       invuln,
  output logic       dead
);

  localparam int CD_W = (HIT_COOLDOWN > 1) ? $clog2(HIT_COOLDOWN + 1) : 1;

  localparam logic [9:0] P_XMIN = 10'(PLAYER_W / 2);
  localparam logic [9:0] P_XMAX = 10'(SCREEN_W - 1 - PLAYER_W / 2);
  localparam logic [9:0] P_YMIN = 10'(PLAYER_H / 2);
  localparam logic [9:0] P_YMAX = 10'(SCREEN_H - 1 - PLAYER_H / 2);
  localparam logic [9:0] E_XMIN = 10'(ENEMY_W / 2);
  localparam logic [9:0] E_XMAX = 10'(SCREEN_W - 1 - ENEMY_W / 2);
  localparam logic [9:0] E_YMIN = 10'(ENEMY_H / 2);
  localparam logic [9:0] E_YMAX = 10'(SCREEN_H - 1 - ENEMY_H / 2);

  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic [CD_W-1:0]    CD_INIT = CD_W'(HIT_COOLDOWN);
  localparam logic [CD_W-1:0]    CD_ONE  = CD_W'(1);

  state_t          state;
  logic            fclk_cur;
  logic            fclk_prev;
  logic            frame_edge;
  logic [9:0]      px, py, ex, ey;
  logic            ex_neg, ey_neg;  // 1 = moving toward smaller coordinate
  logic [CD_W-1:0] cooldown;

  logic [9:0]      px_nx, py_nx, ex_nx, ey_nx;
  logic            ex_neg_nx, ey_neg_nx;
  logic [CD_W-1:0] cd_nx;
  logic [2:0]      hp_nx;
  logic            overlap;

  assign frame_edge  = fclk_cur & ~fclk_prev;

  assign BallX       = px;
  assign BallY       = py;
  assign BallX1      = ex;
  assign BallY1      = ey;
  assign Ball_sizeX  = 10'(PLAYER_W);
  assign Ball_sizeY  = 10'(PLAYER_H);
  assign Ball_sizeX1 = 10'(ENEMY_W);
  assign Ball_sizeY1 = 10'(ENEMY_H);

  aabb_overlap u_aabb (
    .ax      (px),
    .ay      (py),
    .aw      (Ball_sizeX),
    .ah      (Ball_sizeY),
    .bx      (ex),
    .by      (ey),
    .bw      (Ball_sizeX1),
    .bh      (Ball_sizeY1),
    .overlap (overlap)
  );

  // Player step: a dead player stays put; unknown keys hold position.
  always_comb begin
    px_nx = px;
    py_nx = py;
    if (!dead) begin
      case (keycode)
        KEY_A:   px_nx = clamp_step(px, -STEP_S, P_XMIN, P_XMAX);
        KEY_D:   px_nx = clamp_step(px,  STEP_S, P_XMIN, P_XMAX);
        KEY_W:   py_nx = clamp_step(py, -STEP_S, P_YMIN, P_YMAX);
        KEY_S:   py_nx = clamp_step(py,  STEP_S, P_YMIN, P_YMAX);
        default: ;
      endcase
    end
  end

  // Enemy step: flip an outward-moving axis at the wall first, then move
  // along the (possibly flipped) direction in the same update.
  always_comb begin
    ex_neg_nx = ex_neg;
    ey_neg_nx = ey_neg;
    if (!ex_neg && ex >= E_XMAX)     ex_neg_nx = 1'b1;
    else if (ex_neg && ex <= E_XMIN) ex_neg_nx = 1'b0;
    if (!ey_neg && ey >= E_YMAX)     ey_neg_nx = 1'b1;
    else if (ey_neg && ey <= E_YMIN) ey_neg_nx = 1'b0;
    ex_nx = ex_neg_nx ? (ex - 10'd1) : (ex + 10'd1);
    ey_nx = ey_neg_nx ? (ey - 10'd1) : (ey + 10'd1);
  end

  // A hit both costs health and rearms the cooldown, so it never also
  // decrements the cooldown in the same frame.
  always_comb begin
    hp_nx = hp;
    cd_nx = cooldown;
    if (overlap && cooldown == '0 && hp != 3'd0) begin
      hp_nx = hp - 3'd1;
      cd_nx = CD_INIT;
    end else if (cooldown != '0) begin
      cd_nx = cooldown - CD_ONE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      fclk_cur  <= 1'b0;
      fclk_prev <= 1'b0;
      px        <= 10'd160;
      py        <= 10'd400;
      ex        <= 10'd480;
      ey        <= 10'd240;
      ex_neg    <= 1'b0;
      ey_neg    <= 1'b0;
      hp        <= 3'(MAX_HP);
      cooldown  <= '0;
      invuln    <= 1'b0;
      dead      <= 1'b0;
    end else begin
      fclk_cur  <= frame_clk;
      fclk_prev <= fclk_cur;
      case (state)
        // Edges seen outside IDLE are simply not looked at, i.e. dropped.
        IDLE: begin
          if (frame_edge) state <= MOVE_P;
        end
        MOVE_P: begin
          px    <= px_nx;
          py    <= py_nx;
          state <= MOVE_E;
        end
        MOVE_E: begin
          ex     <= ex_nx;
          ey     <= ey_nx;
          ex_neg <= ex_neg_nx;
          ey_neg <= ey_neg_nx;
          state  <= HIT_CHK;
        end
        HIT_CHK: begin
          hp       <= hp_nx;
          cooldown <= cd_nx;
          invuln   <= (cd_nx != '0);
          dead     <= (hp_nx == 3'd0);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entity_motion_ctrl.sv
module tb_entity_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] BallX, BallY, Ball_sizeX, Ball_sizeY;
  logic [9:0] BallX1, BallY1, Ball_sizeX1, Ball_sizeY1;
  logic [2:0] hp;
  logic       invuln, dead;

  entity_motion_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .BallX       (BallX),
    .BallY       (BallY),
    .Ball_sizeX  (Ball_sizeX),
    .Ball_sizeY  (Ball_sizeY),
    .BallX1      (BallX1),
    .BallY1      (BallY1),
    .Ball_sizeX1 (Ball_sizeX1),
    .Ball_sizeY1 (Ball_sizeY1),
    .hp          (hp),
    .invuln      (invuln),
    .dead        (dead)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  localparam logic [7:0] K_A = 8'h04, K_D = 8'h07, K_W = 8'h1A, K_S = 8'h16;

  // Scoreboard: each entry names an output, its required value and the
  // cycle (negedge after that many posedges) at which it must hold.
  typedef struct {
    int    due;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model state.
  int m_px, m_py, m_ex, m_ey, m_vx, m_vy, m_hp, m_cd;
  bit m_dead;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int lim(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [9:0] get_act(input int sel);
    case (sel)
      0:  return BallX;
      1:  return BallY;
      2:  return BallX1;
      3:  return BallY1;
      4:  return {7'd0, hp};
      5:  return {9'd0, invuln};
      6:  return {9'd0, dead};
      7:  return Ball_sizeX;
      8:  return Ball_sizeY;
      9:  return Ball_sizeX1;
      10: return Ball_sizeY1;
      default: return 10'h3FF;
    endcase
  endfunction

  // Monitor: independent of stimulus, compares every entry that falls due.
  always @(negedge Clk) begin
    int i;
    logic [9:0] act;
    logic [9:0] req;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        act = get_act(sb[i].sel);
        req = 10'(sb[i].val);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d want=%0d", sb[i].name, cyc, act, req);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(input int due, input int sel, input int val, input string name);
    exp_t e;
    e.due = due; e.sel = sel; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic push_state(input int due, input string tag);
    push(due, 0, m_px, {tag, ".BallX"});
    push(due, 1, m_py, {tag, ".BallY"});
    push(due, 2, m_ex, {tag, ".BallX1"});
    push(due, 3, m_ey, {tag, ".BallY1"});
    push(due, 4, m_hp, {tag, ".hp"});
    push(due, 5, (m_cd != 0) ? 1 : 0, {tag, ".invuln"});
    push(due, 6, m_dead ? 1 : 0, {tag, ".dead"});
  endtask

  task automatic model_reset();
    m_px = 160; m_py = 400; m_ex = 480; m_ey = 240;
    m_vx = 1; m_vy = 1; m_hp = 5; m_cd = 0; m_dead = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] key);
    bit ov;
    if (!m_dead) begin
      case (key)
        K_A: m_px = lim(m_px - 2, 16, 623);
        K_D: m_px = lim(m_px + 2, 16, 623);
        K_W: m_py = lim(m_py - 2, 24, 455);
        K_S: m_py = lim(m_py + 2, 24, 455);
        default: ;
      endcase
    end
    if (m_ex >= 619 && m_vx > 0)      m_vx = -1;
    else if (m_ex <= 20 && m_vx < 0)  m_vx = 1;
    if (m_ey >= 459 && m_vy > 0)      m_vy = -1;
    else if (m_ey <= 20 && m_vy < 0)  m_vy = 1;
    m_ex = m_ex + m_vx;
    m_ey = m_ey + m_vy;
    ov = (2 * iabs(m_px - m_ex) < 72) && (2 * iabs(m_py - m_ey) < 88);
    if (ov && m_cd == 0 && m_hp > 0) begin
      m_hp = m_hp - 1;
      m_cd = 60;
    end else if (m_cd > 0) begin
      m_cd = m_cd - 1;
    end
    m_dead = (m_hp == 0);
  endtask

  // One frame tick, called right after a negedge. With glitch set, the
  // tick drops and rises again so a second edge lands while busy.
  task automatic do_frame(input logic [7:0] key, input bit glitch);
    int start;
    int hp_before;
    bit dead_before;
    start       = cyc;
    hp_before   = m_hp;
    dead_before = m_dead;
    keycode     = key;
    frame_clk   = 1'b1;
    model_frame(key);
    push_state(start + 5, "frame");
    if (hp_before == 5 && m_hp == 4) begin
      push(start + 5, 4, 4, "first_hit.hp");
      push(start + 5, 5, 1, "first_hit.invuln");
    end
    if (!dead_before && m_dead) push(start + 5, 6, 1, "death.dead");
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      if (glitch && i == 2) frame_clk = 1'b0;
      if (glitch && i == 3) frame_clk = 1'b1;
      if (i == 7) frame_clk = 1'b0;
    end
  endtask

  initial begin
    int start;
    int guard;
    int dx, dy, px_dead;
    logic [7:0] key;

    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    model_reset();
    repeat (2) @(negedge Clk);
    push_state(cyc + 1, "reset");
    push(cyc + 1, 7, 32, "size_px");
    push(cyc + 1, 8, 48, "size_py");
    push(cyc + 1, 9, 40, "size_ex");
    push(cyc + 1, 10, 40, "size_ey");
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // First frame with D, including update latency per stage.
    start = cyc;
    push(start + 2, 0, 160, "lat.BallX_old");
    push(start + 3, 0, 162, "lat.BallX_new");
    push(start + 3, 2, 480, "lat.BallX1_old");
    push(start + 4, 2, 481, "lat.BallX1_new");
    push(start + 5, 1, 400, "f1.BallY");
    push(start + 5, 3, 241, "f1.BallY1");
    do_frame(K_D, 1'b0);

    // Extra edge while busy must be ignored: one step only.
    start = cyc;
    push(start + 9, 0, 164, "busy_edge.BallX");
    push(start + 9, 2, 482, "busy_edge.BallX1");
    do_frame(K_D, 1'b1);

    // Walk left to X=18, then into the left bound.
    repeat (73) do_frame(K_A, 1'b0);
    start = cyc;
    push(start + 5, 0, 16, "left_clamp1");
    do_frame(K_A, 1'b0);
    start = cyc;
    push(start + 5, 0, 16, "left_clamp2");
    do_frame(K_A, 1'b0);

    // Idle until the enemy reaches the right bound, then see it bounce.
    guard = 0;
    while (m_ex != 619 && guard < 200) begin
      do_frame(8'h00, 1'b0);
      guard++;
    end
    start = cyc;
    push(start + 5, 2, 618, "bounce.BallX1");
    push(start + 5, 3, 380, "bounce.BallY1");
    do_frame(8'h00, 1'b0);

    // Chase the enemy until health runs out.
    guard = 0;
    while (!m_dead && guard < 1500) begin
      dx = m_ex - m_px;
      dy = m_ey - m_py;
      if (iabs(dx) >= iabs(dy)) key = (dx > 0) ? K_D : ((dx < 0) ? K_A : 8'h00);
      else                      key = (dy > 0) ? K_S : K_W;
      do_frame(key, 1'b0);
      guard++;
    end
    if (!m_dead) begin
      n_checks++;
      $display("FAIL chase_to_death got=alive want=dead within 1500 frames");
    end

    // Dead: D no longer moves the player, enemy keeps moving.
    px_dead = m_px;
    repeat (3) begin
      start = cyc;
      push(start + 5, 0, px_dead, "dead_hold.BallX");
      push(start + 5, 6, 1, "dead_hold.dead");
      do_frame(K_D, 1'b0);
    end

    // Reset asserted while the update sits in MOVE_E.
    keycode   = K_D;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    Reset     = 1'b1;
    frame_clk = 1'b0;
    model_reset();
    push_state(cyc + 1, "rst_mid");
    push(cyc + 1, 0, 160, "rst_mid.px_const");
    push(cyc + 1, 2, 480, "rst_mid.ex_const");
    push(cyc + 1, 4, 5, "rst_mid.hp_const");
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    start = cyc;
    push(start + 5, 0, 162, "post_rst.BallX");
    push(start + 5, 2, 481, "post_rst.BallX1");
    push(start + 5, 3, 241, "post_rst.BallY1");
    do_frame(K_D, 1'b0);

    repeat (4) @(negedge Clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain got=%0d want=0 pending entries", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
